// File: rtl/nn_burst_master.sv
// nn_burst_master: Avalon-MM burst master that runs one write or read burst per start command.
// Ports:
//   clk, n_rst                     clock, asynchronous active-low reset
//   start, cmd_write, cmd_address,
//   cmd_burstcount                 command strobe and burst descriptor
//   src_data, src_valid, src_ready write-data source handshake
//   snk_data, snk_valid            read-data sink, one valid cycle per beat
//   busy, done, error              command status
//   write, read, beginbursttransfer,
//   address, burstcount, writedata,
//   waitrequest, readdatavalid,
//   readdata, response             Avalon-MM master port
module nn_burst_master #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 13,
  parameter int BURST_W   = 10,
  parameter int MAX_BURST = 512,
  parameter int TIMEOUT   = 1024
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic               start,
  input  logic               cmd_write,
  input  logic [ADDR_W-1:0]  cmd_address,
  input  logic [BURST_W-1:0] cmd_burstcount,
  input  logic [DATA_W-1:0]  src_data,
  input  logic               src_valid,
  output logic               src_ready,
  output logic [DATA_W-1:0]  snk_data,
  output logic               snk_valid,
  output logic               busy,
  output logic               done,
  output logic               error,
  output logic               write,
  output logic               read,
  output logic               beginbursttransfer,
  output logic [ADDR_W-1:0]  address,
  output logic [BURST_W-1:0] burstcount,
  output logic [DATA_W-1:0]  writedata,
  input  logic               waitrequest,
  input  logic               readdatavalid,
  input  logic [DATA_W-1:0]  readdata,
  input  logic [1:0]         response
);
  typedef enum logic [2:0] {IDLE, WR_BURST, RD_CMD, RD_DATA, FINISH} state_t;
  localparam int TO_W = $clog2(TIMEOUT + 1);
  localparam logic [BURST_W-1:0] MAX_B = BURST_W'(MAX_BURST);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);
  state_t state_q;
  logic bad_q, started_q, busy_q, done_q, error_q;
  logic [ADDR_W-1:0] addr_q;
  logic [BURST_W-1:0] bc_q, beat_q, beat_d;
  logic [TO_W-1:0] to_q;
  logic accept;
  // An illegal burst parks in WR_BURST/RD_CMD for one cycle with the bus held quiet.
  assign write = state_q == WR_BURST && !bad_q && src_valid;
  assign read = state_q == RD_CMD && !bad_q;
  assign beginbursttransfer = (write || read) && !started_q;
  assign accept = write && !waitrequest;
  assign src_ready = accept;
  assign writedata = state_q == WR_BURST ? src_data : '0;
  assign snk_valid = state_q == RD_DATA && readdatavalid;
  assign snk_data = readdata;
  assign beat_d = beat_q + 1'b1;
  assign address = addr_q;
  assign burstcount = bc_q;
  assign busy = busy_q;
  assign done = done_q;
  assign error = error_q;
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q   <= IDLE;
      bad_q     <= 1'b0;
      started_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      addr_q    <= '0;
      bc_q      <= '0;
      beat_q    <= '0;
      to_q      <= '0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          addr_q    <= cmd_address;
          bc_q      <= cmd_burstcount;
          bad_q     <= cmd_burstcount == '0 || cmd_burstcount > MAX_B;
          error_q   <= 1'b0;
          busy_q    <= 1'b1;
          started_q <= 1'b0;
          beat_q    <= '0;
          to_q      <= '0;
          state_q   <= cmd_write ? WR_BURST : RD_CMD;
        end
        WR_BURST: if (bad_q) begin
          error_q <= 1'b1;
          done_q  <= 1'b1;
          state_q <= FINISH;
        end else begin
          if (write) started_q <= 1'b1;
          if (accept) begin
            beat_q <= beat_d;
            if (beat_d == bc_q) begin
              done_q  <= 1'b1;
              state_q <= FINISH;
            end
          end
        end
        RD_CMD: if (bad_q) begin
          error_q <= 1'b1;
          done_q  <= 1'b1;
          state_q <= FINISH;
        end else begin
          started_q <= 1'b1;
          if (!waitrequest) state_q <= RD_DATA;
        end
        RD_DATA: if (readdatavalid) begin
          beat_q <= beat_d;
          to_q   <= '0;
          if (response != 2'b00) error_q <= 1'b1;
          if (beat_d == bc_q) begin
            done_q  <= 1'b1;
            state_q <= FINISH;
          end
        end else if (to_q == TO_LAST) begin
          error_q <= 1'b1;
          done_q  <= 1'b1;
          state_q <= FINISH;
        end else begin
          to_q <= to_q + 1'b1;
        end
        FINISH: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_nn_burst_master.sv
// tb_nn_burst_master: directed scoreboard bench for nn_burst_master.
module tb_nn_burst_master;
  localparam int DW = 32, AW = 13, BW = 10;
  logic clk = 0, n_rst = 0, start = 0, cmd_write = 0;
  logic [AW-1:0] cmd_address = '0;
  logic [BW-1:0] cmd_burstcount = '0;
  logic [DW-1:0] src_data = '0;
  logic src_valid = 0, src_ready;
  logic [DW-1:0] snk_data;
  logic snk_valid, busy, done, error, write, read, beginbursttransfer;
  logic [AW-1:0] address;
  logic [BW-1:0] burstcount;
  logic [DW-1:0] writedata;
  logic waitrequest = 0, readdatavalid = 0;
  logic [DW-1:0] readdata = '0;
  logic [1:0] response = '0;
  int checks = 0, errors = 0;
  logic [DW-1:0] exp_wr[$], exp_rd[$];
  logic exp_done[$];
  logic [AW-1:0] exp_addr = '0;
  logic [BW-1:0] exp_bc = '0;
  int n_wr = 0, n_rd = 0, n_bbt = 0, n_acc = 0;
  nn_burst_master dut (
    .clk(clk), .n_rst(n_rst), .start(start), .cmd_write(cmd_write),
    .cmd_address(cmd_address), .cmd_burstcount(cmd_burstcount),
    .src_data(src_data), .src_valid(src_valid), .src_ready(src_ready),
    .snk_data(snk_data), .snk_valid(snk_valid), .busy(busy), .done(done), .error(error),
    .write(write), .read(read), .beginbursttransfer(beginbursttransfer),
    .address(address), .burstcount(burstcount), .writedata(writedata),
    .waitrequest(waitrequest), .readdatavalid(readdatavalid),
    .readdata(readdata), .response(response)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask
  task automatic miss(input string name);
    checks++;
    errors++;
    $display("FAIL %s: DUT output with nothing expected", name);
  endtask
  always @(negedge clk) if (n_rst) begin
    if (write) n_wr++;
    if (read) n_rd++;
    if (beginbursttransfer) n_bbt++;
    if (write || read) begin
      chk("bus_address", address, exp_addr);
      chk("bus_burstcount", burstcount, exp_bc);
    end
    if (src_ready) begin
      n_acc++;
      if (exp_wr.size() > 0) chk("writedata", writedata, exp_wr.pop_front());
      else miss("writedata");
    end
    if (snk_valid) begin
      if (exp_rd.size() > 0) chk("snk_data", snk_data, exp_rd.pop_front());
      else miss("snk_data");
    end
    if (done) begin
      if (exp_done.size() > 0) chk("done_error", error, exp_done.pop_front());
      else miss("done");
    end
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, "_write"}, write, 0);
    chk({tag, "_read"}, read, 0);
    chk({tag, "_bbt"}, beginbursttransfer, 0);
    chk({tag, "_src_ready"}, src_ready, 0);
    chk({tag, "_snk_valid"}, snk_valid, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_error"}, error, 0);
    chk({tag, "_address"}, address, 0);
    chk({tag, "_burstcount"}, burstcount, 0);
    chk({tag, "_writedata"}, writedata, 0);
  endtask
  task automatic issue(input logic wr, input logic [AW-1:0] a, input logic [BW-1:0] bc);
    exp_addr = a;
    exp_bc = bc;
    n_wr = 0; n_rd = 0; n_bbt = 0; n_acc = 0;
    start = 1; cmd_write = wr; cmd_address = a; cmd_burstcount = bc;
    step();
    start = 0;
    chk("busy_after_start", busy, 1);
    chk("error_cleared_on_start", error, 0);
  endtask
  task automatic wr_burst(input logic [AW-1:0] a, input int bc, input logic [DW-1:0] base,
                          input int gap, input int wt);
    int k = 0, c = 0, nvalid = 0;
    logic acc;
    for (int i = 0; i < bc; i++) exp_wr.push_back(base + DW'(i));
    exp_done.push_back(1'b0);
    issue(1'b1, a, BW'(bc));
    while (k < bc && c < 32) begin
      src_valid = !gap[c];
      src_data = base + DW'(k);
      waitrequest = wt[c];
      if (!gap[c]) nvalid++;
      #1 acc = src_ready;
      step();
      c++;
      if (acc) k++;
    end
    chk("wr_beats", k, bc);
    chk("wr_done_after_last", done, 1);
    chk("wr_write_low_after_last", write, 0);
    src_valid = 0;
    waitrequest = 0;
    step();
    chk("wr_busy_cleared", busy, 0);
    chk("wr_accepts", n_acc, bc);
    chk("wr_write_cycles", n_wr, nvalid);
    chk("wr_bbt_count", n_bbt, 1);
    chk("wr_queue_empty", exp_wr.size(), 0);
  endtask
  task automatic rd_burst(input logic [AW-1:0] a, input int bc, input int nw, input logic [DW-1:0] base,
                          input int gap, input int errbeat, input int ign_start);
    int k = 0, c = 0;
    for (int i = 0; i < bc; i++) exp_rd.push_back(base + DW'(i));
    exp_done.push_back(errbeat >= 0);
    issue(1'b0, a, BW'(bc));
    waitrequest = 1;
    readdatavalid = 1;
    readdata = 32'hDEAD_BEEF;
    repeat (nw) step();
    waitrequest = 0;
    step();
    readdatavalid = 0;
    while (k < bc && c < 32) begin
      readdatavalid = !gap[c];
      readdata = base + DW'(k);
      response = (k == errbeat) ? 2'b10 : 2'b00;
      start = (c == ign_start);
      cmd_write = 1;
      cmd_burstcount = 5;
      step();
      if (readdatavalid) k++;
      c++;
    end
    start = 0;
    readdatavalid = 0;
    response = 0;
    chk("rd_beats", k, bc);
    chk("rd_done_after_last", done, 1);
    step();
    chk("rd_busy_cleared", busy, 0);
    chk("rd_read_cycles", n_rd, nw + 1);
    chk("rd_bbt_count", n_bbt, 1);
    chk("rd_queue_empty", exp_rd.size(), 0);
  endtask
  task automatic illegal(input logic wr, input int bc);
    exp_done.push_back(1'b1);
    src_valid = 1;
    waitrequest = 0;
    issue(wr, 13'h020, BW'(bc));
    chk("illegal_no_early_done", done, 0);
    step();
    chk("illegal_done_2cyc", done, 1);
    chk("illegal_error", error, 1);
    step();
    src_valid = 0;
    chk("illegal_busy_cleared", busy, 0);
    chk("illegal_no_bus", n_wr + n_rd + n_bbt, 0);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    int c;
    repeat (2) step();
    chk_zero("reset");
    n_rst = 1;
    wr_burst(13'h010, 4, 32'h1111_0000, 0, 0);
    wr_burst(13'h010, 3, 32'h2222_0000, 32'h10, 32'h6);
    rd_burst(13'h100, 8, 3, 32'hA000_0000, 32'h32, -1, 2);
    rd_burst(13'h0AB, 2, 0, 32'hB000_0000, 0, 1, -1);
    step();
    step();
    chk("error_held", error, 1);
    wr_burst(13'h011, 1, 32'h3333_0000, 0, 0);
    chk("error_clean_after_burst", error, 0);
    illegal(1'b1, 0);
    illegal(1'b0, 513);
    exp_done.push_back(1'b1);
    exp_rd.push_back(32'hC000_0000);
    issue(1'b0, 13'h040, 2);
    waitrequest = 0;
    step();
    repeat (600) step();
    readdatavalid = 1;
    readdata = 32'hC000_0000;
    step();
    readdatavalid = 0;
    c = 0;
    while (!done && c < 2000) begin
      step();
      c++;
    end
    chk("timeout_cycles", c, 1024);
    chk("timeout_error", error, 1);
    step();
    chk("timeout_busy_cleared", busy, 0);
    exp_wr.push_back(32'h4444_0000);
    exp_wr.push_back(32'h4444_0001);
    issue(1'b1, 13'h080, 4);
    src_valid = 1;
    waitrequest = 0;
    src_data = 32'h4444_0000;
    step();
    src_data = 32'h4444_0001;
    step();
    waitrequest = 1;
    src_data = 32'h4444_0002;
    #2 n_rst = 0;
    #1 chk_zero("async_reset");
    chk("reset_wr_queue", exp_wr.size(), 0);
    src_valid = 0;
    waitrequest = 0;
    repeat (2) step();
    n_rst = 1;
    wr_burst(13'h012, 2, 32'h5555_0000, 0, 0);
    chk("done_queue_empty", exp_done.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/nn_burst_master.md
NN_BURST_MASTER -- requirements
Module: nn_burst_master

Interface
REQ-001 Parameters SHALL be: DATA_W, default 32, data width; ADDR_W, default 13, word address width; BURST_W, default 10, burstcount width; MAX_BURST, default 512, largest legal burst; TIMEOUT, default 1024, idle cycles allowed while waiting for read data.
REQ-002 Ports SHALL be:
- clk  in  1  clock; all logic on rising edge.
- n_rst  in  1  reset; asynchronous, active-low.
- start  in  1  command strobe.
- cmd_write  in  1  1 = burst write, 0 = burst read.
- cmd_address  in  ADDR_W  burst start address.
- cmd_burstcount  in  BURST_W  beats in burst.
- src_data  in  DATA_W  write-data source.
- src_valid  in  1  src_data valid.
- src_ready  out  1  source word consumed this cycle.
- snk_data  out  DATA_W  read-data sink.
- snk_valid  out  1  snk_data valid, one cycle per beat.
- busy  out  1  command in progress.
- done  out  1  one-cycle completion pulse.
- error  out  1  status of the last command.
- write, read, beginbursttransfer  out  1 each  Avalon-MM master controls.
- address  out  ADDR_W; burstcount  out  BURST_W; writedata  out  DATA_W.
- waitrequest, readdatavalid  in  1 each; readdata  in  DATA_W; response  in  2.

Function
REQ-003 The state machine SHALL have the states IDLE, WR_BURST, RD_CMD, RD_DATA and FINISH.
REQ-004 In IDLE, start=1 SHALL latch cmd_write, cmd_address and cmd_burstcount, clear error, and raise busy on the next cycle.
REQ-005 start while busy=1 SHALL be ignored.
REQ-006 A latched burstcount of 0 or greater than MAX_BURST SHALL go directly to FINISH with error=1 and no bus activity.
REQ-007 address and burstcount SHALL hold the latched values, unchanged, from the first bus cycle until the last beat is accepted.
REQ-008 WR_BURST behaviour:
- write = src_valid; writedata = src_data.
- A beat is accepted when write=1 and waitrequest=0.
- src_ready SHALL equal the accept condition.
- A beat counter SHALL count accepted beats.
- src_valid=0 SHALL deassert write for that cycle (gap); the burst continues afterward.
REQ-009 beginbursttransfer SHALL be high for exactly one cycle per burst: the first cycle in which write or read is asserted for that burst, regardless of waitrequest.
REQ-010 On acceptance of beat N = burstcount, WR_BURST SHALL go to FINISH; write SHALL be low in the following cycle.
REQ-011 RD_CMD SHALL hold read=1 until waitrequest=0, then go to RD_DATA with read=0; only one read command is issued per burst.
REQ-012 In RD_DATA, each readdatavalid=1 cycle SHALL drive:
- snk_data = readdata and snk_valid=1 in the same cycle (combinational pass-through);
- increment of the beat counter;
- error=1 if response != 2'b00.
REQ-013 After the last read beat, RD_DATA SHALL go to FINISH.
REQ-014 readdatavalid arriving in any state other than RD_DATA SHALL be ignored and SHALL NOT drive snk_valid.
REQ-015 In RD_DATA, TIMEOUT consecutive cycles without readdatavalid SHALL set error=1 and go to FINISH.
REQ-016 The timeout counter SHALL reset on every beat.
REQ-017 FINISH SHALL last one cycle with done=1 and busy=1, then return to IDLE with busy=0.
REQ-018 error SHALL hold its value until the next accepted start.
REQ-019 The beat counter SHALL be BURST_W bits wide and SHALL NOT wrap within a legal burst.

Reset
REQ-020 n_rst=0 SHALL asynchronously force:
- state IDLE;
- all counters to 0;
- write, read, beginbursttransfer, src_ready, snk_valid, busy, done and error to 0;
- address, burstcount and writedata to 0.
REQ-021 Reset asserted mid-burst SHALL abandon the burst immediately, with no done pulse.
REQ-022 After reset release, the block SHALL accept start on the first clock edge.

Verification
REQ-023 Write, burstcount=4, address=0x010, src_valid held high, waitrequest=0 -> write high 4 cycles, beginbursttransfer only on the first, 4 src_ready pulses, done 1 cycle after the last beat, error=0.
REQ-024 Write, burstcount=3, waitrequest=1 for 2 cycles on beat 2, src_valid=0 for 1 cycle before beat 3 -> address=0x010 stable throughout, exactly 3 accepts, writedata matches the source sequence.
REQ-025 Read, burstcount=8, address=0x100, waitrequest=1 for 3 cycles, then 8 readdatavalid beats with gaps -> read high 4 cycles, 8 snk_valid beats equal to readdata, done, error=0.
REQ-026 Read, burstcount=2, second beat carries response=2'b10 -> error=1 after done; a following clean burst clears error.
REQ-027 Illegal burstcount=0, then burstcount=513 -> no write or read asserted, done 2 cycles after start, error=1 for each.
REQ-028 Read with no readdatavalid -> done and error=1 after 1024 idle cycles; n_rst pulse mid-write -> all outputs 0 immediately.
